// File: rtl/cell4_sweep_pkg.sv
// Shared types and constants for the NAND4 cell sweep controller.
package cell4_sweep_pkg;

    localparam int unsigned NUM_VEC  = 16;
    localparam logic [15:0] NAND4_TT = 16'h7FFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SAMPLE,
        ST_FIN
    } sweep_state_e;

endpackage

// File: rtl/cell4_settle_timer.sv
// Load / count-down settle timer; expired is high once the count reaches zero.
module cell4_settle_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/cell4_sweep_ctrl.sv
// Walks all 16 input vectors through a 4-input cell, holding each to settle,
// and records which vectors produced an unexpected zn.
module cell4_sweep_ctrl
    import cell4_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] EXP_TT        = NAND4_TT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        zn,
    output logic        a1,
    output logic        a2,
    output logic        a3,
    output logic        a4,
    output logic [3:0]  vec_idx,
    output logic        busy,
    output logic        done,
    output logic [15:0] fail_mask,
    output logic [4:0]  err_count
);

    localparam logic [3:0] LAST_VEC = 4'(NUM_VEC - 1);
    // HOLD leaves on the cycle the timer reads zero, so load one less.
    localparam logic [3:0] HOLD_LOAD = 4'(SETTLE_CYCLES - 1);

    sweep_state_e state_q, state_d;
    logic [3:0]   vec_q, vec_d;
    logic [15:0]  mask_q, mask_d;
    logic [4:0]   err_q, err_d;
    logic         tmr_load, tmr_expired, mismatch;

    cell4_settle_timer #(.CNT_W(4)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (HOLD_LOAD),
        .en       (state_q == ST_HOLD),
        .expired  (tmr_expired)
    );

    assign mismatch = (zn != EXP_TT[vec_q]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            mask_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start && !abort) state_d = ST_HOLD;
            ST_HOLD:   if (abort) state_d = ST_IDLE;
                       else if (tmr_expired) state_d = ST_SAMPLE;
            ST_SAMPLE: if (abort) state_d = ST_IDLE;
                       else if (vec_q == LAST_VEC) state_d = ST_FIN;
                       else state_d = ST_HOLD;
            ST_FIN:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath follows the state transitions; an aborted SAMPLE records nothing.
    always_comb begin
        vec_d    = vec_q;
        mask_d   = mask_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        case (state_q)
            ST_IDLE: if (start && !abort) begin
                vec_d    = '0;
                mask_d   = '0;
                err_d    = '0;
                tmr_load = 1'b1;
            end
            ST_HOLD: if (abort) vec_d = '0;
            ST_SAMPLE: begin
                if (abort) begin
                    vec_d = '0;
                end else begin
                    if (mismatch) begin
                        mask_d[vec_q] = 1'b1;
                        err_d         = err_q + 5'd1;
                    end
                    if (vec_q != LAST_VEC) begin
                        vec_d    = vec_q + 4'd1;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_FIN:  vec_d = '0;
            default: vec_d = '0;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_HOLD) || (state_q == ST_SAMPLE);
        done = (state_q == ST_FIN);
    end

    assign {a1, a2, a3, a4} = vec_q;
    assign vec_idx          = vec_q;
    assign fail_mask        = mask_q;
    assign err_count        = err_q;

endmodule

// File: tb/tb_cell4_sweep_ctrl.sv
// Scoreboard bench for cell4_sweep_ctrl driving a behavioural NAND4 cell model.
module tb_cell4_sweep_ctrl;

    localparam int S       = 2;
    localparam int VEC_CYC = S + 1;
    localparam int LAT     = 16 * VEC_CYC + 1;

    logic        clk = 1'b0;
    logic        rst, start, abort, zn;
    logic        a1, a2, a3, a4, busy, done;
    logic [3:0]  vec_idx;
    logic [15:0] fail_mask;
    logic [4:0]  err_count;

    int checks = 0;
    int errors = 0;
    int mode   = 0;  // 0 ideal NAND4, 1 zn stuck at 1, 2 zn stuck at 0

    typedef struct {
        logic [15:0] mask;
        logic [4:0]  cnt;
    } exp_t;
    exp_t sb_q[$];

    cell4_sweep_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .zn(zn),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4), .vec_idx(vec_idx),
        .busy(busy), .done(done), .fail_mask(fail_mask), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            0:       zn = ~(a1 & a2 & a3 & a4);
            1:       zn = 1'b1;
            default: zn = 1'b0;
        endcase
    end

    function automatic exp_t model(input int m);
        exp_t e;
        logic [3:0] v;
        logic good, z;
        e.mask = '0;
        e.cnt  = '0;
        for (int i = 0; i < 16; i++) begin
            v    = 4'(i);
            good = ~&v;
            z    = (m == 0) ? good : (m == 1) ? 1'b1 : 1'b0;
            if (z != good) begin
                e.mask[i] = 1'b1;
                e.cnt     = e.cnt + 5'd1;
            end
        end
        return e;
    endfunction

    // Done monitor: every pulse must match a queued expectation.
    exp_t got_e;
    always @(posedge clk) begin
        #1;
        checks++;
        if (int'(err_count) !== $countones(fail_mask)) begin
            errors++;
            $display("FAIL popcount: err_count=%0d fail_mask=%h", err_count, fail_mask);
        end
        if (done === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 want no pulse");
            end else begin
                got_e = sb_q.pop_front();
                checks += 2;
                if (fail_mask !== got_e.mask) begin
                    errors++;
                    $display("FAIL done_mask: got %h want %h", fail_mask, got_e.mask);
                end
                if (err_count !== got_e.cnt) begin
                    errors++;
                    $display("FAIL done_count: got %0d want %0d", err_count, got_e.cnt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [15:0] m, input logic [4:0] c);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || vec_idx !== 4'd0 || {a1, a2, a3, a4} !== 4'd0 ||
            fail_mask !== m || err_count !== c) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b vec=%0d a=%b mask=%h cnt=%0d want idle mask=%h cnt=%0d",
                     tag, busy, done, vec_idx, {a1, a2, a3, a4}, fail_mask, err_count, m, c);
        end
    endtask

    // Waits for done from the cycle after start was accepted; checks vector order and latency.
    task automatic follow_sweep(input string tag);
        int k = 1;
        int bad = 0;
        while (done !== 1'b1 && k < LAT + 20) begin
            if (busy !== 1'b1 || vec_idx !== 4'((k - 1) / VEC_CYC) || {a1, a2, a3, a4} !== vec_idx)
                bad++;
            tick();
            k++;
        end
        checks += 3;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_order: %0d bad cycles want 0", tag, bad);
        end
        if (k != LAT) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles want %0d", tag, k, LAT);
        end
        if (busy !== 1'b0 || vec_idx !== 4'd15) begin
            errors++;
            $display("FAIL %s_fin: busy=%b vec=%0d want busy=0 vec=15", tag, busy, vec_idx);
        end
    endtask

    task automatic run_sweep(input string tag, input int m);
        exp_t e = model(m);
        mode = m;
        sb_q.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        follow_sweep(tag);
        tick();
        check_idle({tag, "_after"}, e.mask, e.cnt);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b0;
        tick(); tick();
        check_idle("reset", 16'h0, 5'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        check_idle("reset_release", 16'h0, 5'd0);
    endtask

    task automatic test_abort(input string tag, input int extra);
        int n = 0;
        mode = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (vec_idx !== 4'd5 && n < 200) begin tick(); n++; end
        checks++;
        if (vec_idx !== 4'd5) begin
            errors++;
            $display("FAIL %s_reach: vec=%0d want 5", tag, vec_idx);
        end
        repeat (extra) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle(tag, 16'h001F, 5'd5);
        repeat (60) tick();
        check_idle({tag, "_hold"}, 16'h001F, 5'd5);
    endtask

    task automatic test_abort_start_idle();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_idle("abort_start_idle", 16'h001F, 5'd5);
    endtask

    task automatic test_rst_mid();
        int n = 0;
        mode = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (vec_idx !== 4'd9 && n < 200) begin tick(); n++; end
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        check_idle("rst_mid", 16'h0, 5'd0);
        repeat (60) tick();
        run_sweep("rst_then_clean", 0);
    endtask

    task automatic test_start_held();
        int n = 0;
        exp_t e = model(0);
        mode = 0;
        sb_q.push_back(e);
        start = 1'b1;
        tick();
        follow_sweep("held1");
        tick();
        check_idle("held_idle_gap", e.mask, e.cnt);
        sb_q.push_back(e);
        tick();
        checks++;
        if (busy !== 1'b1 || vec_idx !== 4'd0) begin
            errors++;
            $display("FAIL held_restart: busy=%b vec=%0d want busy=1 vec=0", busy, vec_idx);
        end
        start = 1'b0;
        while (done !== 1'b1 && n < LAT + 20) begin tick(); n++; end
        tick();
        check_idle("held2_after", e.mask, e.cnt);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        test_reset();
        run_sweep("ideal", 0);
        run_sweep("stuck1", 1);
        run_sweep("stuck0", 2);
        test_abort("abort_hold", 0);
        test_abort_start_idle();
        test_abort("abort_sample", S);
        test_rst_mid();
        test_start_held();
        repeat (5) tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_done: %0d expected sweeps never completed", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cell4_sweep_ctrl.md
CELL4_SWEEP_CTRL -- requirements
Module: cell4_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of extra cycles each vector is held before zn is sampled; legal range 1..15.
REQ-002 Parameter EXP_TT, default 16'h7FFF, expected zn per vector index (bit i = expected zn for vector i); the default is the 4-input NAND truth table.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a full 16-vector sweep; sampled only in IDLE.
REQ-006 abort  input  1  terminate a running sweep.
REQ-007 zn  input  1  output of the cell under test.
REQ-008 a1, a2, a3, a4  output  1 each  registered stimulus to the cell; a1 = vec_idx[3], a4 = vec_idx[0].
REQ-009 vec_idx  output  4  index of the vector currently applied.
REQ-010 busy  output  1  high while a sweep is running.
REQ-011 done  output  1  one-cycle pulse on sweep completion.
REQ-012 fail_mask  output  16  bit i set when vector i mismatched.
REQ-013 err_count  output  5  number of mismatching vectors, 0..16.

Function
REQ-014 The FSM SHALL have states IDLE, HOLD, SAMPLE, FIN.
REQ-015 IDLE + start: next cycle HOLD, vec_idx=0, a1..a4=0000, busy=1, fail_mask=0, err_count=0.
REQ-016 HOLD SHALL last exactly SETTLE_CYCLES cycles with stimulus unchanged, then go to SAMPLE.
REQ-017 SAMPLE (1 cycle, stimulus still held) SHALL compare zn with EXP_TT[vec_idx]; on mismatch set fail_mask[vec_idx] and increment err_count.
REQ-018 From SAMPLE with vec_idx<15: vec_idx+1, stimulus updated the next cycle, go to HOLD; with vec_idx=15: go to FIN.
REQ-019 Each vector SHALL be applied for SETTLE_CYCLES+1 cycles; start-accept to done = 16*(SETTLE_CYCLES+1)+1 cycles.
REQ-020 FIN: done=1 and busy=0 for exactly one cycle, then IDLE; vec_idx does not wrap past 15.
REQ-021 In IDLE, a1..a4 SHALL be 0000 and vec_idx 0; fail_mask and err_count hold the last results until the next start.
REQ-022 start while busy SHALL be ignored.
REQ-023 abort in HOLD or SAMPLE: next cycle IDLE, busy=0, done not asserted, partial fail_mask/err_count retained; a mismatch in that same SAMPLE cycle is NOT recorded.
REQ-024 abort and start together in IDLE: abort wins, no sweep starts.
REQ-025 err_count SHALL equal the popcount of fail_mask at all times.

Reset
REQ-026 rst SHALL force IDLE, a1..a4=0000, vec_idx=0, busy=0, done=0, fail_mask=0, err_count=0, settle counter=0.
REQ-027 rst mid-sweep SHALL abandon the sweep with no done pulse; rst takes priority over start and abort.

Structure
REQ-028 Package cell4_sweep_pkg SHALL hold the state enum, NUM_VEC=16, and the NAND4 truth-table constant 16'h7FFF.
REQ-029 The hold counter SHALL be a sub-module cell4_settle_timer (load, count-down, expire flag).

Verification
REQ-030 Ideal NAND4 model, SETTLE_CYCLES=2, start pulse -> done 49 cycles later, fail_mask=0, err_count=0, vectors 0000..1111 applied in order.
REQ-031 Model with zn stuck at 1 -> fail_mask=16'h8000, err_count=1.
REQ-032 Model with zn stuck at 0 -> fail_mask=16'h7FFF, err_count=15.
REQ-033 abort asserted while vec_idx=5, zn stuck at 0 -> busy drops next cycle, no done, err_count=5, fail_mask=16'h001F.
REQ-034 rst during vec_idx=9, then fresh start with ideal model -> clean sweep, no done from the first sweep, final err_count=0.
REQ-035 start held high through the sweep -> exactly one done per sweep, and a new sweep starts only from IDLE.
